// File: rtl/regfile_wb_sink_pkg.sv
// Shared constants, types and the pending-counter saturation helper for regfile_wb_sink.
package regfile_wb_sink_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = '0;

    // A counter of width w is saturated once it reaches 2^w-1 (w up to 8).
    function automatic logic pend_full(input logic [7:0] cnt, input int unsigned w);
        logic [8:0] max_val;
        max_val = (9'd1 << w) - 9'd1;
        return ({1'b0, cnt} == max_val);
    endfunction

endpackage

// File: rtl/regfile_wb_sink_sb_counter.sv
// Saturating up/down in-flight-writer counter for one architectural register.
module sb_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         zero,
    output logic         full,
    output logic         underflow
);
    import regfile_wb_sink_pkg::*;

    assign zero = (count == '0);
    assign full = pend_full(8'(count), W);
    // Clear wins, so a retire in a flush cycle is never reported as an underflow.
    assign underflow = dec & ~inc & zero & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + W'(1);
        end else if (dec && !inc && !zero) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/regfile_wb_sink.sv
// Decode-stage register file with per-register pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN: write-through reads and busy masking on final retire.
module regfile_wb_sink
    import regfile_wb_sink_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int PEND_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] wb_data,
    input  reg_idx_t        wb_rd,
    input  logic            wb_reg_write,
    input  reg_idx_t        rs1_addr,
    input  reg_idx_t        rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            iss_valid,
    input  reg_idx_t        iss_rd,
    input  logic            iss_reg_write,
    output logic            iss_ready,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            flush,
    output logic            sb_err
);

    logic [XLEN-1:0]   regs [NREGS];
    logic [PEND_W-1:0] cnt  [NREGS];
    logic [NREGS-1:0]  zero_vec;
    logic [NREGS-1:0]  full_vec;
    logic [NREGS-1:0]  uflow_vec;
    logic              iss_eff;
    logic              ret_eff;

    assign ret_eff = wb_reg_write && (wb_rd != ZERO_REG);

    // Issue handshake: an issue is taken when iss_valid & iss_ready; iss_ready only
    // drops for a register whose counter is saturated and not retiring this cycle.
    assign iss_ready = !(iss_valid && iss_reg_write && (iss_rd != ZERO_REG) &&
                         full_vec[iss_rd] && !(ret_eff && (wb_rd == iss_rd)));
    assign iss_eff   = iss_valid && iss_reg_write && iss_ready && (iss_rd != ZERO_REG);

    assign cnt[0]       = '0;
    assign zero_vec[0]  = 1'b1;
    assign full_vec[0]  = 1'b0;
    assign uflow_vec[0] = 1'b0;

    for (genvar i = 1; i < NREGS; i++) begin : g_cnt
        sb_counter #(.W(PEND_W)) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (iss_eff && (iss_rd == reg_idx_t'(i))),
            .dec       (ret_eff && (wb_rd == reg_idx_t'(i))),
            .clr       (flush),
            .count     (cnt[i]),
            .zero      (zero_vec[i]),
            .full      (full_vec[i]),
            .underflow (uflow_vec[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (ret_eff) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_err <= 1'b0;
        end else if (|uflow_vec) begin
            sb_err <= 1'b1;
        end
    end

    logic rs1_raw_busy;
    logic rs2_raw_busy;
    assign rs1_raw_busy = (rs1_addr != ZERO_REG) && !zero_vec[rs1_addr];
    assign rs2_raw_busy = (rs2_addr != ZERO_REG) && !zero_vec[rs2_addr];

`ifdef REGFILE_BYPASS_EN
    logic rs1_fwd;
    logic rs2_fwd;
    logic rs1_last;
    logic rs2_last;
    assign rs1_fwd  = ret_eff && (wb_rd == rs1_addr);
    assign rs2_fwd  = ret_eff && (wb_rd == rs2_addr);
    // Final retire of the last in-flight writer, with no new writer arriving.
    assign rs1_last = rs1_fwd && (cnt[rs1_addr] == PEND_W'(1)) &&
                      !(iss_eff && (iss_rd == rs1_addr));
    assign rs2_last = rs2_fwd && (cnt[rs2_addr] == PEND_W'(1)) &&
                      !(iss_eff && (iss_rd == rs2_addr));

    assign rs1_data = (rs1_addr == ZERO_REG) ? '0 : (rs1_fwd ? wb_data : regs[rs1_addr]);
    assign rs2_data = (rs2_addr == ZERO_REG) ? '0 : (rs2_fwd ? wb_data : regs[rs2_addr]);
    assign rs1_busy = rs1_raw_busy && !rs1_last;
    assign rs2_busy = rs2_raw_busy && !rs2_last;
`else
    assign rs1_data = (rs1_addr == ZERO_REG) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == ZERO_REG) ? '0 : regs[rs2_addr];
    assign rs1_busy = rs1_raw_busy;
    assign rs2_busy = rs2_raw_busy;
`endif

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Directed self-checking bench for regfile_wb_sink (default and REGFILE_BYPASS_EN builds).
module tb_regfile_wb_sink;
    import regfile_wb_sink_pkg::*;

    logic            clk;
    logic            rst_n;
    logic [XLEN-1:0] wb_data;
    reg_idx_t        wb_rd;
    logic            wb_reg_write;
    reg_idx_t        rs1_addr;
    reg_idx_t        rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            iss_valid;
    reg_idx_t        iss_rd;
    logic            iss_reg_write;
    logic            iss_ready;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            flush;
    logic            sb_err;

    int checks;
    int failures;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] EXP_SAME_CYCLE = 32'hDEADBEEF;
    localparam logic [31:0] EXP_LAST_BUSY  = 32'd0;
`else
    localparam logic [31:0] EXP_SAME_CYCLE = 32'd0;
    localparam logic [31:0] EXP_LAST_BUSY  = 32'd1;
`endif

    regfile_wb_sink dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_data       (wb_data),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .iss_valid     (iss_valid),
        .iss_rd        (iss_rd),
        .iss_reg_write (iss_reg_write),
        .iss_ready     (iss_ready),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .flush         (flush),
        .sb_err        (sb_err)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        wb_data = '0; wb_rd = '0; wb_reg_write = 1'b0;
        iss_valid = 1'b0; iss_rd = '0; iss_reg_write = 1'b0;
        flush = 1'b0;
    endtask

    task automatic drive_issue(input reg_idx_t rd);
        iss_valid = 1'b1; iss_rd = rd; iss_reg_write = 1'b1;
    endtask

    task automatic drive_wb(input reg_idx_t rd, input logic [31:0] data);
        wb_reg_write = 1'b1; wb_rd = rd; wb_data = data;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        drive_idle();
        #12;
        check("rst_rs1_data", rs1_data, 32'd0);
        check("rst_busy", {30'd0, rs1_busy, rs2_busy}, 32'd0);
        check("rst_sb_err", {31'd0, sb_err}, 32'd0);
        rst_n = 1'b1;
        step();

        // Write-then-read on x5 (one writer issued first so the retire is legal)
        drive_issue(5'd5);
        #1;
        check("iss5_ready", {31'd0, iss_ready}, 32'd1);
        step();
        drive_idle();
        drive_wb(5'd5, 32'hDEADBEEF);
        rs1_addr = 5'd5;
        #1;
        check("wb5_same_cycle", rs1_data, EXP_SAME_CYCLE);
        check("wb5_busy_last", {31'd0, rs1_busy}, EXP_LAST_BUSY);
        step();
        drive_idle();
        #1;
        check("wb5_next_cycle", rs1_data, 32'hDEADBEEF);
        check("wb5_busy_after", {31'd0, rs1_busy}, 32'd0);

        // x0: writes discarded, issues ignored
        drive_wb(5'd0, 32'hFFFFFFFF);
        drive_issue(5'd0);
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        #1;
        check("x0_rs2_same", rs2_data, 32'd0);
        check("x0_iss_ready", {31'd0, iss_ready}, 32'd1);
        step();
        drive_idle();
        #1;
        check("x0_rs2_after", rs2_data, 32'd0);
        check("x0_rs1_busy", {31'd0, rs1_busy}, 32'd0);
        check("x0_sb_err", {31'd0, sb_err}, 32'd0);

        // Scoreboard: two writers to x7
        drive_issue(5'd7);
        step();
        step();
        drive_idle();
        rs1_addr = 5'd7;
        #1;
        check("x7_busy_2", {31'd0, rs1_busy}, 32'd1);
        drive_wb(5'd7, 32'h11);
        #1;
        check("x7_busy_retire_from_2", {31'd0, rs1_busy}, 32'd1);
        step();
        drive_idle();
        #1;
        check("x7_busy_1", {31'd0, rs1_busy}, 32'd1);
        drive_wb(5'd7, 32'h22);
        step();
        drive_idle();
        #1;
        check("x7_busy_0", {31'd0, rs1_busy}, 32'd0);
        check("x7_data", rs1_data, 32'h22);
        check("x7_sb_err", {31'd0, sb_err}, 32'd0);

        // Saturation on x3
        for (int i = 0; i < 3; i++) begin
            drive_issue(5'd3);
            #1;
            check($sformatf("x3_ready_%0d", i), {31'd0, iss_ready}, 32'd1);
            step();
        end
        drive_issue(5'd3);
        #1;
        check("x3_ready_sat", {31'd0, iss_ready}, 32'd0);
        step();
        drive_wb(5'd3, 32'h33);
        #1;
        check("x3_ready_sat_retire", {31'd0, iss_ready}, 32'd1);
        step();
        drive_idle();
        drive_issue(5'd3);
        rs2_addr = 5'd3;
        #1;
        check("x3_still_sat", {31'd0, iss_ready}, 32'd0);
        check("x3_busy", {31'd0, rs2_busy}, 32'd1);
        step();

        // Flush overrides a same-cycle issue; then an underflowing retire
        drive_idle();
        drive_issue(5'd9);
        step();
        step();
        drive_idle();
        rs1_addr = 5'd9;
        #1;
        check("x9_busy_pre_flush", {31'd0, rs1_busy}, 32'd1);
        flush = 1'b1;
        drive_issue(5'd9);
        step();
        drive_idle();
        #1;
        check("x9_busy_flushed", {31'd0, rs1_busy}, 32'd0);
        check("x3_busy_flushed", {31'd0, rs2_busy}, 32'd0);
        check("flush_no_err", {31'd0, sb_err}, 32'd0);
        drive_wb(5'd9, 32'h99);
        step();
        drive_idle();
        #1;
        check("x9_underflow_err", {31'd0, sb_err}, 32'd1);
        check("x9_data", rs1_data, 32'h99);
        check("x9_busy_after_uflow", {31'd0, rs1_busy}, 32'd0);
        step();
        step();
        check("sb_err_sticky", {31'd0, sb_err}, 32'd1);

        // Asynchronous reset between edges with a pending writer
        drive_issue(5'd7);
        step();
        drive_idle();
        rs1_addr = 5'd7;
        rs2_addr = 5'd5;
        #1;
        check("pre_rst_busy", {31'd0, rs1_busy}, 32'd1);
        check("pre_rst_x5", rs2_data, 32'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", {30'd0, rs1_busy, rs2_busy}, 32'd0);
        check("async_rst_x5", rs2_data, 32'd0);
        check("async_rst_x7", rs1_data, 32'd0);
        check("async_rst_err", {31'd0, sb_err}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
